// File: rtl/io_bus_pkg.sv
// Shared types and constants for the two-requester memory_io arbiter.
// Holds the downstream command encoding and the arbiter state encoding.
package io_bus_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IO_IDLE  = 2'b00,
    IO_READ  = 2'b01,
    IO_WRITE = 2'b10
  } io_ctrl_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } arb_state_t;

  function automatic io_ctrl_t cmd_for(input logic is_write);
    return is_write ? IO_WRITE : IO_READ;
  endfunction

endpackage

// File: rtl/io_bus_arbiter_if.sv
// Bundle of requester-side and memory_io-side signals around the arbiter.
// master = arbiter view, slave = requesters plus downstream memory view.
interface io_bus_arbiter_if;
  import io_bus_pkg::*;

  // Handshake: a requester raises req[i] with we/addr/wdata and holds all of
  // them stable until ack[i] pulses for one cycle; it drops req by the edge
  // that ends the ack cycle. rdata is valid only while ack is high. req is
  // only looked at while the arbiter is idle, so there is no backpressure
  // beyond waiting for ack.
  logic [1:0]        req;
  logic [1:0]        we;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic [1:0]        ack;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] address_io;
  logic [DATA_W-1:0] data_out_io;
  io_ctrl_t          control_io;
  logic [DATA_W-1:0] data_in_io;
  logic              busy;

  modport master (
    input  req, we, addr0, addr1, wdata0, wdata1, data_in_io,
    output ack, rdata, address_io, data_out_io, control_io, busy
  );

  modport slave (
    output req, we, addr0, addr1, wdata0, wdata1, data_in_io,
    input  ack, rdata, address_io, data_out_io, control_io, busy
  );

endinterface

// File: rtl/io_bus_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker: on a tie the requester that was
// not granted last wins; a lone request always wins.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_idx
);

  always_comb begin
    grant_valid = |req;
    grant_idx   = 1'b0;
    if (req == 2'b11) begin
      grant_idx = ~last_grant;
    end else begin
      grant_idx = req[1];
    end
  end

endmodule

// File: rtl/io_bus_arbiter.sv
// Shares the single memory_io port between core (0) and secondary master (1):
// one transaction at a time, one-cycle strobe, fixed latency, one-cycle ack.
import io_bus_pkg::*;

module io_bus_arbiter #(
  parameter int IO_LATENCY = 2
) (
  input  logic              main_clk,
  input  logic              reset,
  io_bus_arbiter_if.master  bus,
  output arb_state_t        state_dbg
);

  // Counter starts at IO_LATENCY-1 while in ISSUE, so ISSUE itself counts as
  // the first latency cycle and IO_LATENCY=1 goes straight from ISSUE to RESP.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(IO_LATENCY - 1);

  arb_state_t        state_q, state_n;
  logic              grant_q, grant_n;
  logic              we_q, we_n;
  logic              last_grant_q, last_grant_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [DATA_W-1:0] wdata_q, wdata_n;
  io_ctrl_t          ctrl_q, ctrl_n;
  logic [1:0]        ack_q, ack_n;
  logic [DATA_W-1:0] rdata_q, rdata_n;
  logic              busy_q, busy_n;

  logic pick_valid;
  logic pick_idx;

  rr_pick2 u_pick (
    .req         (bus.req),
    .last_grant  (last_grant_q),
    .grant_valid (pick_valid),
    .grant_idx   (pick_idx)
  );

  always_comb begin
    state_n      = state_q;
    grant_n      = grant_q;
    we_n         = we_q;
    last_grant_n = last_grant_q;
    cnt_n        = cnt_q;
    addr_n       = addr_q;
    wdata_n      = wdata_q;
    rdata_n      = rdata_q;
    ctrl_n       = IO_IDLE;
    ack_n        = 2'b00;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_n = ISSUE;
          grant_n = pick_idx;
          we_n    = bus.we[pick_idx];
          addr_n  = pick_idx ? bus.addr1 : bus.addr0;
          wdata_n = pick_idx ? bus.wdata1 : bus.wdata0;
          ctrl_n  = cmd_for(bus.we[pick_idx]);
          cnt_n   = CNT_LOAD;
        end
      end
      ISSUE, WAIT: begin
        if (cnt_q == '0) begin
          state_n = RESP;
          ack_n   = grant_q ? 2'b10 : 2'b01;
          if (!we_q) begin
            rdata_n = bus.data_in_io;
          end
        end else begin
          state_n = WAIT;
          cnt_n   = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        last_grant_n = grant_q;
        state_n      = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge main_clk) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      we_q         <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      ctrl_q       <= IO_IDLE;
      ack_q        <= 2'b00;
      rdata_q      <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_n;
      grant_q      <= grant_n;
      we_q         <= we_n;
      last_grant_q <= last_grant_n;
      cnt_q        <= cnt_n;
      addr_q       <= addr_n;
      wdata_q      <= wdata_n;
      ctrl_q       <= ctrl_n;
      ack_q        <= ack_n;
      rdata_q      <= rdata_n;
      busy_q       <= busy_n;
    end
  end

  assign bus.address_io  = addr_q;
  assign bus.data_out_io = wdata_q;
  assign bus.control_io  = ctrl_q;
  assign bus.ack         = ack_q;
  assign bus.rdata       = rdata_q;
  assign bus.busy        = busy_q;
  assign state_dbg       = state_q;

endmodule
